dct_zigzag_quant: RTL
=====================

# dct_zigzag_quant

Downstream stage of the 8x8 2-D DCT. It accepts the 64 DCT coefficients of one block in row-major order and buffers them. It then emits them in JPEG zigzag order, each divided by the standard JPEG luminance quantisation table using reciprocal multiplication. Its output feeds the run-length/entropy stage and the display path.

## Interface
Parameters:
- `CW`, 12: coefficient width, signed two's complement, on both input and output.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_data`  in  CW  DCT coefficient, signed; the n-th accepted word is element n, with n = 8*row + col.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word; a word transfers when `in_valid` and `in_ready` are both high at an edge.
- `out_data`  out  CW  quantised coefficient, signed.
- `out_index`  out  6  zigzag position of `out_data`, 0..63.
- `out_last`  out  1  high with `out_index` == 63.
- `out_valid`  out  1  output fields are valid.
- `out_ready`  in  1  downstream accepts; a word transfers when `out_valid` and `out_ready` are both high at an edge.

## Operation
- 64 x CW coefficient buffer, single bank. There is no overlap between loading one block and draining the previous one.
- State machine with three states:
  - LOAD: `in_ready`=1. Each accepted word is written to `buf[wr_ptr]` and `wr_ptr` increments. When the word with `wr_ptr`==63 is accepted, go to PREP.
  - PREP: one cycle. `in_ready`=0. The output register loads zigzag element 0, `out_valid` is set, and the state goes to DRAIN.
  - DRAIN: `in_ready`=0.
    - On an output handshake with `out_index`<63, the output register loads element `out_index`+1.
    - On the handshake with `out_index`==63, clear `out_valid` and `out_last`, clear `wr_ptr`, and go to LOAD.
- `in_ready` is a pure decode of state; it does not depend on `in_valid`.
- Zigzag map `zz[k]` gives the raster address for zigzag position k. It is the standard JPEG order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Quantisation:
  - Divisor `Q[r]` is taken from the JPEG Annex K luminance table, indexed by raster address r: row 0 is 16,11,10,16,24,40,51,61; row 7 is 72,92,95,98,112,100,103,99.
  - Reciprocal `R[r]` = round(65536/`Q[r]`), 16-bit unsigned constant.
  - `out_data` = sign(c) * ((|c| * `R[zz[k]]` + 32768) >> 16), with c = `buf[zz[k]]`. Rounding is half away from zero.
  - The intermediate product is CW+16 bits unsigned. The result always fits in CW bits because every Q is at least 10; no saturation is needed.
  - |-2048| = 2048 is handled as an unsigned magnitude.
- Inputs presented while `in_ready`=0 are ignored. `out_ready` is ignored while `out_valid`=0.

## Timing
- Reset values: `in_ready`=1 (state LOAD), `out_valid`=0, `out_last`=0, `out_data`=0, `out_index`=0, `wr_ptr`=0. Buffer contents are not reset.
- Latency: the 64th input is accepted at edge E. PREP is occupied between E and E+1, and `out_valid`=1 with `out_index`=0 is visible after E+1.
- Back-pressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` hold stable.
- Minimum block period is 129 cycles: 64 loads, 1 PREP cycle, 64 drains. With `out_ready` held high, one output word is produced per cycle.
- After the final output handshake at edge F, `in_ready`=1 from F onward. A new input can be accepted at edge F+1.
- `rst_n`=0 at any edge, including mid-load or mid-drain, discards the partial block and restores all reset values at that edge.

## Configuration
- `ZZQ_QUANT_EN` defined: quantisation is performed as described in Operation.
- `ZZQ_QUANT_EN` undefined: the reciprocal table and multiplier are not built. `out_data` = `buf[zz[k]]` unchanged, giving zigzag reordering only. Timing, handshakes and the state machine are identical.

## Test plan
- Load raster value n at address n (`ZZQ_QUANT_EN` undefined), `out_ready`=1 → outputs follow the zz sequence 0,1,8,16,9,2,…,63; `out_last` is high only on 63; `out_valid` rises at E+1.
- `ZZQ_QUANT_EN` defined, element 0 = 1024, −1024, 8, 7 in four separate blocks → `out_data` at `out_index`=0 is 64, −64, 1, 0 respectively.
- `ZZQ_QUANT_EN` defined, all 64 inputs = −2048 → every output equals −round(2048/`Q[r]`); e.g. index 0 = −128, index 63 = −21.
- `out_ready` toggles on alternate cycles → each output is held across stall cycles, no word is dropped or duplicated, and the block completes in 64 handshakes.
- `in_valid` held high throughout the drain → no extra inputs are accepted; the next block's element 0 is accepted at F+1.
- `rst_n` pulsed low after 30 inputs, then a full block is sent → the output is the new block only, with `out_index` starting at 0.

Source files
------------

// File: rtl/dct_zigzag_quant.sv
// Buffers one 8x8 block of DCT coefficients in raster order and drains it in JPEG zigzag order.
// Optional macro ZZQ_QUANT_EN adds luminance-table quantisation via reciprocal multiplication.
module dct_zigzag_quant #(
    parameter int CW = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [CW-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [CW-1:0] out_data,
    output logic [5:0]           out_index,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PREP  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    state_t          state_q, state_d;
    logic [5:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   out_data_q, out_data_d;
    logic [5:0]      out_index_q, out_index_d;
    logic            out_last_q, out_last_d;
    logic            out_valid_q, out_valid_d;
    logic            buf_we;

    logic [CW-1:0]   buf_mem [64];
    logic [5:0]      rd_k;
    logic [5:0]      rd_addr;
    logic [CW-1:0]   rd_coef;
    logic [CW-1:0]   coef_val;

    // Zigzag position of the element to present next: 0 from PREP, otherwise the successor.
    assign rd_k    = (state_q == ST_PREP) ? 6'd0 : out_index_q + 6'd1;
    assign rd_addr = 6'(ZZ[rd_k]);
    assign rd_coef = buf_mem[rd_addr];

`ifdef ZZQ_QUANT_EN
    localparam int Q_TAB [64] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };

    logic [15:0]     recip_rom [64];
    logic            coef_neg;
    logic [CW-1:0]   coef_mag;
    logic [CW+15:0]  prod;
    logic [CW-1:0]   quot_mag;

    for (genvar gi = 0; gi < 64; gi++) begin : g_recip
        assign recip_rom[gi] = 16'((65536 + Q_TAB[gi] / 2) / Q_TAB[gi]);
    end

    // Magnitude is unsigned so -2^(CW-1) maps cleanly to 2^(CW-1).
    always_comb begin
        coef_neg = rd_coef[CW-1];
        coef_mag = coef_neg ? CW'(-rd_coef) : rd_coef;
        prod     = (CW+16)'(coef_mag) * (CW+16)'(recip_rom[rd_addr]);
        quot_mag = CW'((prod + (CW+16)'(32768)) >> 16);
        coef_val = coef_neg ? CW'(-quot_mag) : quot_mag;
    end
`else
    assign coef_val = rd_coef;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        buf_we      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 6'd1;
                    if (wr_ptr_q == 6'd63) begin
                        state_d = ST_PREP;
                    end
                end
            end
            ST_PREP: begin
                out_data_d  = coef_val;
                out_index_d = 6'd0;
                out_last_d  = 1'b0;
                out_valid_d = 1'b1;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (out_index_q == 6'd63) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        wr_ptr_d    = 6'd0;
                        state_d     = ST_LOAD;
                    end else begin
                        out_data_d  = coef_val;
                        out_index_d = rd_k;
                        out_last_d  = (rd_k == 6'd63);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= 6'd0;
            out_data_q  <= '0;
            out_index_q <= 6'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Coefficient storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_ptr_q] <= in_data;
        end
    end

    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule
